// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared widths and FSM state type for the I2C slave front end
package i2c_slave_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } i2c_slave_state_t;
endpackage

// File: rtl/i2c_slave_phy_if.sv
// i2c_slave_phy_if: bus lines plus byte-stream handshake between PHY and back end
interface i2c_slave_phy_if;
  import i2c_slave_pkg::*;
  logic                  scl_i;
  logic                  sda_i;
  logic                  sda_o;
  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [I2C_BYTE_W-1:0] tx_data;
  logic                  tx_req;
  logic                  start_det;
  logic                  stop_det;
  logic                  busy;
  logic                  rwn;
  modport slave (
    input  scl_i, sda_i, rx_ready, tx_data,
    output sda_o, rx_data, rx_valid, tx_req, start_det, stop_det, busy, rwn
  );
  modport master (
    output scl_i, sda_i, rx_ready, tx_data,
    input  sda_o, rx_data, rx_valid, tx_req, start_det, stop_det, busy, rwn
  );
endinterface

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: multi-flop synchroniser with single-cycle rise/fall pulses
module i2c_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  // shift the pin through the synchroniser and keep one extra flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;
endmodule

// File: rtl/i2c_slave_phy.sv
// i2c_slave_phy: I2C slave bit/byte engine with START/STOP detect, address match and ACK drive
module i2c_slave_phy import i2c_slave_pkg::*; #(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h42,
  parameter int                    SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst_n,
  i2c_slave_phy_if.slave bus
);
  logic scl_s, scl_rise, scl_fall, sda_s, sda_rise, sda_fall;
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_scl (
    .clk(clk), .rst_n(rst_n), .d_i(bus.scl_i), .level_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
  );
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sda (
    .clk(clk), .rst_n(rst_n), .d_i(bus.sda_i), .level_o(sda_s), .rise_o(sda_rise), .fall_o(sda_fall)
  );
  i2c_slave_state_t      state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [I2C_BYTE_W-1:0] sh_q, sh_d, rx_data_q, rx_data_d;
  logic arm_q, arm_d, sda_o_q, sda_o_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic start_q, start_d, stop_q, stop_d, busy_q, busy_d, rwn_q, rwn_d, rdy_q, rdy_d;
  logic start, stop, last, match;
  assign start = sda_fall & scl_s;
  assign stop  = sda_rise & scl_s;
  assign last  = cnt_q == 3'd7;
  assign match = sh_q[7:1] == SLAVE_ADDR;
  // next-state logic: bus conditions first, then per-state bit handling on SCL edges
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    arm_d      = arm_q;
    sda_o_d    = sda_o_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    busy_d     = busy_q;
    rwn_d      = rwn_q;
    rdy_d      = rdy_q;
    if (start) begin
      state_d = ADDR;
      cnt_d   = 3'd0;
      arm_d   = 1'b0;
      sda_o_d = 1'b1;
      start_d = 1'b1;
    end else if (stop) begin
      state_d = IDLE;
      sda_o_d = 1'b1;
      stop_d  = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda_s};
            arm_d = 1'b1;
          end
          if (scl_fall && arm_q) begin
            cnt_d = cnt_q + 3'd1;
            if (last) begin
              state_d = match ? ADDR_ACK : IGNORE;
              sda_o_d = ~match;
              rwn_d   = match ? sh_q[0] : rwn_q;
            end
          end
        end
        ADDR_ACK: begin
          tx_req_d = scl_rise & rwn_q;
          if (scl_fall) begin
            busy_d  = 1'b1;
            state_d = rwn_q ? RD_DATA : WR_DATA;
            sh_d    = rwn_q ? bus.tx_data : sh_q;
            sda_o_d = rwn_q ? bus.tx_data[7] : 1'b1;
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            sh_d = {sh_q[6:0], sda_s};
            if (last) begin
              rdy_d      = bus.rx_ready;
              rx_valid_d = bus.rx_ready;
              rx_data_d  = bus.rx_ready ? {sh_q[6:0], sda_s} : rx_data_q;
            end
          end
          if (scl_fall) begin
            cnt_d   = cnt_q + 3'd1;
            state_d = last ? WR_ACK : WR_DATA;
            sda_o_d = last ? ~rdy_q : sda_o_q;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_d = WR_DATA;
            sda_o_d = 1'b1;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            cnt_d   = cnt_q + 3'd1;
            sh_d    = {sh_q[6:0], 1'b0};
            state_d = last ? RD_ACK : RD_DATA;
            sda_o_d = last ? 1'b1 : sh_q[6];
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            tx_req_d = ~sda_s;
            state_d  = sda_s ? IGNORE : RD_ACK;
            busy_d   = ~sda_s & busy_q;
          end
          if (scl_fall) begin
            state_d = RD_DATA;
            sh_d    = bus.tx_data;
            sda_o_d = bus.tx_data[7];
          end
        end
        default: ;
      endcase
    end
  end
  // state and output registers; SDA released and pulses cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      sh_q       <= '0;
      arm_q      <= 1'b0;
      sda_o_q    <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      rwn_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      arm_q      <= arm_d;
      sda_o_q    <= sda_o_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      rwn_q      <= rwn_d;
      rdy_q      <= rdy_d;
    end
  end
  assign bus.sda_o     = sda_o_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_req    = tx_req_q;
  assign bus.start_det = start_q;
  assign bus.stop_det  = stop_q;
  assign bus.busy      = busy_q;
  assign bus.rwn       = rwn_q;
endmodule

// File: tb/tb_i2c_slave_phy.sv
// tb_i2c_slave_phy: directed I2C master model driving the slave PHY with hand-computed expectations
module tb_i2c_slave_phy;
  localparam int STASTO_DELAY = 100;
  localparam int BIT_DELAY    = 1000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  i2c_slave_phy_if bus();
  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & bus.sda_o;
  i2c_slave_phy #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int n_start = 0, n_stop = 0, n_rx = 0, n_tx = 0, n_low = 0, n_busy = 0, n_both = 0;
  int tx_idx = 0;
  logic [7:0] rx_log [64];
  logic [7:0] tx_q [4];
  int s_start, s_stop, s_rx, s_tx, s_low, s_busy;
  int checks = 0, errors = 0;
  // observe DUT pulses away from the active edge; serve read bytes on tx_req
  always @(negedge clk) begin
    if (bus.start_det) n_start++;
    if (bus.stop_det) n_stop++;
    if (bus.rx_valid) begin
      rx_log[n_rx[5:0]] = bus.rx_data;
      n_rx++;
    end
    if (bus.tx_req) begin
      bus.tx_data = tx_q[tx_idx[1:0]];
      tx_idx++;
      n_tx++;
    end
    if (!bus.sda_o) n_low++;
    if (bus.busy) n_busy++;
    if (bus.rx_valid && bus.tx_req) n_both++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic snap();
    s_start = n_start; s_stop = n_stop; s_rx = n_rx; s_tx = n_tx; s_low = n_low; s_busy = n_busy;
  endtask
  task automatic i2c_start();
    m_sda = 1'b1; #STASTO_DELAY;
    m_scl = 1'b1; #STASTO_DELAY;
    m_sda = 1'b0; #STASTO_DELAY;
    m_scl = 1'b0; #STASTO_DELAY;
  endtask
  task automatic i2c_stop();
    m_sda = 1'b0; #STASTO_DELAY;
    m_scl = 1'b1; #STASTO_DELAY;
    m_sda = 1'b1; #STASTO_DELAY;
  endtask
  task automatic slot(input logic b, output logic s);
    #(BIT_DELAY/10) m_sda = b;
    #(BIT_DELAY*15/100) m_scl = 1'b1;
    #(BIT_DELAY/4) s = bus.sda_i;
    #(BIT_DELAY/4) m_scl = 1'b0;
    #(BIT_DELAY/4);
  endtask
  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) slot(b[i], s);
    slot(1'b1, ack);
  endtask
  task automatic rbyte(output logic [7:0] d, input logic mack);
    logic s;
    for (int i = 7; i >= 0; i--) slot(1'b1, d[i]);
    slot(mack, s);
  endtask
  initial begin
    logic a, a2;
    logic [7:0] d;
    tx_q[0] = 8'h3C; tx_q[1] = 8'h81; tx_q[2] = 8'hFF; tx_q[3] = 8'hFF;
    bus.rx_ready = 1'b1;
    #53;
    chk("rst_sda_o", bus.sda_o, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rwn", bus.rwn, 1'b0);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_rx_valid", bus.rx_valid, 1'b0);
    chk("rst_tx_req", bus.tx_req, 1'b0);
    chk("rst_start", bus.start_det, 1'b0);
    chk("rst_stop", bus.stop_det, 1'b0);
    rst_n = 1'b1;
    #200;
    chk("idle_no_start", n_start, 0);
    // single byte write 0xA5 to 0x42
    snap();
    i2c_start();
    wbyte(8'h84, a);
    chk("w1_addr_ack", a, 1'b0);
    wbyte(8'hA5, a);
    chk("w1_data_ack", a, 1'b0);
    chk("w1_busy", bus.busy, 1'b1);
    i2c_stop();
    #300;
    chk("w1_start_cnt", n_start - s_start, 1);
    chk("w1_stop_cnt", n_stop - s_stop, 1);
    chk("w1_rx_cnt", n_rx - s_rx, 1);
    chk("w1_rx_byte", rx_log[s_rx], 8'hA5);
    chk("w1_rx_data_held", bus.rx_data, 8'hA5);
    chk("w1_busy_end", bus.busy, 1'b0);
    chk("w1_rwn", bus.rwn, 1'b0);
    // four byte write
    snap();
    i2c_start();
    wbyte(8'h84, a);
    chk("w4_addr_ack", a, 1'b0);
    wbyte(8'h11, a); wbyte(8'h22, a2);
    chk("w4_ack12", {a, a2}, 2'b00);
    wbyte(8'h33, a); wbyte(8'h44, a2);
    chk("w4_ack34", {a, a2}, 2'b00);
    i2c_stop();
    #300;
    chk("w4_rx_cnt", n_rx - s_rx, 4);
    chk("w4_rx_bytes", {rx_log[s_rx], rx_log[s_rx+1], rx_log[s_rx+2], rx_log[s_rx+3]}, 32'h11223344);
    chk("w4_no_tx_req", n_tx - s_tx, 0);
    // wrong address 0x17
    snap();
    i2c_start();
    wbyte(8'h2E, a);
    wbyte(8'h55, a2);
    chk("wx_nacks", {a, a2}, 2'b11);
    i2c_stop();
    #300;
    chk("wx_sda_low_cycles", n_low - s_low, 0);
    chk("wx_rx_cnt", n_rx - s_rx, 0);
    chk("wx_busy_cycles", n_busy - s_busy, 0);
    chk("wx_start_stop", {n_start - s_start, n_stop - s_stop}, {32'd1, 32'd1});
    // two byte read from 0x42
    snap();
    i2c_start();
    wbyte(8'h85, a);
    chk("rd_addr_ack", a, 1'b0);
    chk("rd_rwn", bus.rwn, 1'b1);
    rbyte(d, 1'b0);
    chk("rd_byte0", d, 8'h3C);
    chk("rd_busy", bus.busy, 1'b1);
    rbyte(d, 1'b0);
    chk("rd_byte1", d, 8'h81);
    i2c_stop();
    #300;
    chk("rd_tx_req_cnt", n_tx - s_tx, 3);
    chk("rd_stop_cnt", n_stop - s_stop, 1);
    chk("rd_busy_end", bus.busy, 1'b0);
    // write with back end not ready
    bus.rx_ready = 1'b0;
    snap();
    i2c_start();
    wbyte(8'h84, a);
    chk("nr_addr_ack", a, 1'b0);
    wbyte(8'h5A, a);
    chk("nr_data_nack", a, 1'b1);
    i2c_stop();
    #300;
    chk("nr_rx_cnt", n_rx - s_rx, 0);
    bus.rx_ready = 1'b1;
    // reset during third data bit, then a clean write
    snap();
    i2c_start();
    wbyte(8'h84, a);
    chk("rs_addr_ack", a, 1'b0);
    slot(1'b1, a); slot(1'b0, a);
    #(BIT_DELAY/10) m_sda = 1'b0;
    #(BIT_DELAY*15/100) m_scl = 1'b1;
    #(BIT_DELAY/4) rst_n = 1'b0;
    #1;
    chk("rs_sda_o", bus.sda_o, 1'b1);
    chk("rs_busy", bus.busy, 1'b0);
    m_sda = 1'b1;
    #200 rst_n = 1'b1;
    #300;
    chk("rs_no_rx", n_rx - s_rx, 0);
    snap();
    i2c_start();
    wbyte(8'h84, a);
    wbyte(8'h96, a2);
    chk("rs_acks", {a, a2}, 2'b00);
    i2c_stop();
    #300;
    chk("rs_rx_cnt", n_rx - s_rx, 1);
    chk("rs_rx_byte", rx_log[s_rx], 8'h96);
    chk("excl_rx_tx", n_both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
